// File: rtl/ps2_kbd_port.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_port
// Function : PS/2 keyboard receiver with scancode FIFO and four-phase
//            KBDready / scancode / KBDread handshake toward the I/O bus.
// Revision : 1.0  initial release
// ============================================================================
module ps2_kbd_port #(
    parameter int FIFO_AW    = 3,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               KBDread,
    output logic               KBDready,
    output logic [7:0]         scancode,
    output logic [FIFO_AW:0]   count,
    output logic               overflow,
    output logic               frame_err
);
    localparam int c_DEPTH = 2 ** FIFO_AW;
    localparam int c_FW    = $clog2(FILTER_LEN + 1);
    localparam int c_TW    = $clog2(TIMEOUT + 1);
    localparam logic [c_FW-1:0] c_FCNT_MAX = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TMO_MAX  = c_TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt, r_fall;
    logic [c_FW-1:0] r_fcnt;
    state_t          r_state;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [c_TW-1:0] r_tmo;
    logic            r_ferr;

    logic [7:0]      r_mem [c_DEPTH];
    logic [FIFO_AW:0] r_wp, r_rp;
    logic            r_ack;
    logic            r_ovf;

    logic            w_empty, w_full, w_pop, w_push, w_wr, w_frame_ok;

    // Synchronizers and clock glitch filter; the filtered level only moves
    // after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_fcnt   <= '0;
            r_fall   <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_FCNT_MAX) begin
                r_filt <= r_clk_s2;
                r_fcnt <= '0;
                r_fall <= r_filt & ~r_clk_s2;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Odd parity across data and parity bit, plus a high stop bit.
    assign w_frame_ok = r_dat_s2 && (^{r_shift, r_par});
    assign w_push     = r_fall && (r_state == S_STOP) && w_frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_par    <= 1'b0;
            r_tmo    <= '0;
            r_ferr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            if (r_fall || r_state == S_IDLE) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (r_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= 3'd0;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift[r_bitcnt] <= r_dat_s2;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_ferr  <= ~w_frame_ok;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE && r_tmo == c_TMO_MAX) begin
                r_state <= S_IDLE;
                r_ferr  <= 1'b1;
            end
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) &&
                     (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
    assign w_pop   = KBDread && KBDready;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp[FIFO_AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ack <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp  <= r_rp + 1'b1;
                r_ack <= 1'b1;
            end else if (!KBDread) begin
                r_ack <= 1'b0;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign KBDready  = !w_empty && !r_ack;
    assign scancode  = w_empty ? 8'h00 : r_mem[r_rp[FIFO_AW-1:0]];
    assign count     = r_wp - r_rp;
    assign overflow  = r_ovf;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire
